trap_controller: RTL and testbench

//  Sequencer directly upstream of the CSR file. Turns a one-cycle trap request (ECALL/EBREAK/misaligned/illegal)
//  or MRET request into the CSR write/read transactions it needs, then reports the redirect PC.
//  A trap writes mepc and mcause, then reads mtvec. MRET reads mepc.

---
 rtl/trap_controller.sv | 151 +++++++++++++++
 tb/tb_trap_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// Trap/MRET sequencer sitting in front of the CSR file: converts a one-cycle trap or MRET
// request into mepc/mcause writes and an mtvec/mepc read, then reports the redirect PC.
module trap_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            csr_ready,
    input  logic [XLEN-1:0] csr_read_data,
    output logic            csr_write_enable,
    output logic [11:0]     csr_write_address,
    output logic [XLEN-1:0] csr_write_data,
    output logic [11:0]     csr_read_address,
    output logic            trapped,
    output logic            trap_busy,
    output logic            trap_done,
    output logic [XLEN-1:0] trap_target_pc
);

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    typedef enum logic [3:0] {
        IDLE,
        WR_EPC,
        GAP1,
        WR_CAUSE,
        GAP2,
        RD_VEC,
        RD_EPC,
        RD_WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-3:0] pc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] target_q;
    logic            mret_q;
    logic            accept_trap;
    logic            accept_mret;
    logic            capture;

    // MODE bits of mtvec are deliberately dropped; only direct mode is supported.
    logic unused_mode;
    assign unused_mode = ^csr_read_data[1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
            mret_q   <= 1'b0;
        end else if (clk_enable) begin
            state <= state_next;
            if (accept_trap) begin
                pc_q    <= trap_pc[XLEN-1:2];
                cause_q <= trap_cause;
                mret_q  <= 1'b0;
            end else if (accept_mret) begin
                mret_q <= 1'b1;
            end
            if (capture) begin
                target_q <= {csr_read_data[XLEN-1:2], 2'b00};
            end
        end
    end

    // NOTE: every output of this block is given a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_next        = state;
        accept_trap       = 1'b0;
        accept_mret       = 1'b0;
        capture           = 1'b0;
        csr_write_enable  = 1'b0;
        csr_write_address = '0;
        csr_write_data    = '0;
        csr_read_address  = '0;

        case (state)
            IDLE: begin
                // A trap outranks a coincident MRET.
                if (trap_valid) begin
                    accept_trap = 1'b1;
                    state_next  = WR_EPC;
                end else if (mret_valid) begin
                    accept_mret = 1'b1;
                    state_next  = RD_EPC;
                end
            end
            WR_EPC: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MEPC;
                csr_write_data    = {pc_q, 2'b00};
                state_next        = GAP1;
            end
            GAP1: begin
                // Strobe drops for a cycle so the CSR file sees a fresh rising edge.
                state_next = WR_CAUSE;
            end
            WR_CAUSE: begin
                csr_write_enable  = 1'b1;
                csr_write_address = CSR_MCAUSE;
                csr_write_data    = cause_q;
                state_next        = GAP2;
            end
            GAP2: begin
                state_next = RD_VEC;
            end
            RD_VEC: begin
                csr_read_address = CSR_MTVEC;
                state_next       = RD_WAIT;
            end
            RD_EPC: begin
                csr_read_address = CSR_MEPC;
                state_next       = RD_WAIT;
            end
            RD_WAIT: begin
                csr_read_address = mret_q ? CSR_MEPC : CSR_MTVEC;
                if (csr_ready) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign trapped        = (state == WR_EPC) || (state == GAP1) ||
                            (state == WR_CAUSE) || (state == GAP2);
    assign trap_busy      = (state != IDLE);
    assign trap_done      = (state == DONE);
    assign trap_target_pc = target_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: a behavioural CSR file plus directed and randomized trap/MRET
// transactions checked against an architectural mepc/mcause/mtvec model.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_enable;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_valid;
    logic        csr_ready;
    logic [31:0] csr_read_data;
    logic        csr_write_enable;
    logic [11:0] csr_write_address;
    logic [31:0] csr_write_data;
    logic [11:0] csr_read_address;
    logic        trapped;
    logic        trap_busy;
    logic        trap_done;
    logic [31:0] trap_target_pc;

    int total = 0;
    int bad   = 0;

    trap_controller #(.XLEN(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .clk_enable       (clk_enable),
        .trap_valid       (trap_valid),
        .trap_cause       (trap_cause),
        .trap_pc          (trap_pc),
        .mret_valid       (mret_valid),
        .csr_ready        (csr_ready),
        .csr_read_data    (csr_read_data),
        .csr_write_enable (csr_write_enable),
        .csr_write_address(csr_write_address),
        .csr_write_data   (csr_write_data),
        .csr_read_address (csr_read_address),
        .trapped          (trapped),
        .trap_busy        (trap_busy),
        .trap_done        (trap_done),
        .trap_target_pc   (trap_target_pc)
    );

    always #5 clk = ~clk;

    // Behavioural CSR file: commits on a rising write strobe, registered read,
    // ready low for one cycle whenever the read address changes.
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wlog[$];
    logic [31:0] mepc_m    = '0;
    logic [31:0] mcause_m  = '0;
    logic [31:0] mtvec_cfg = '0;
    logic        we_prev   = 1'b0;
    logic [11:0] last_addr = '0;
    logic        ready_q   = 1'b1;
    logic [31:0] rdata_q   = '0;

    function automatic logic [31:0] csr_peek(input logic [11:0] a);
        case (a)
            12'h305: return mtvec_cfg;
            12'h341: return mepc_m;
            12'h342: return mcause_m;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (clk_enable) begin
            if (csr_write_enable && !we_prev) begin
                if (csr_write_address == 12'h341) mepc_m <= csr_write_data;
                if (csr_write_address == 12'h342) mcause_m <= csr_write_data;
                wlog.push_back('{addr: csr_write_address, data: csr_write_data});
            end
            we_prev <= csr_write_enable;
            if (csr_read_address != last_addr) begin
                last_addr <= csr_read_address;
                ready_q   <= 1'b0;
            end else begin
                ready_q <= 1'b1;
            end
            rdata_q <= csr_peek(csr_read_address);
        end
    end

    assign csr_ready     = ready_q;
    assign csr_read_data = rdata_q;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Output invariants that must hold on every cycle.
    always @(negedge clk) begin
        if (!csr_write_enable) begin
            check("idle waddr", {20'h0, csr_write_address}, 32'h0);
            check("idle wdata", csr_write_data, 32'h0);
        end
        if (!trap_busy) begin
            check("idle raddr", {20'h0, csr_read_address}, 32'h0);
            check("idle trapped", {31'h0, trapped}, 32'h0);
            check("idle done", {31'h0, trap_done}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural reference state
    logic [31:0] mepc_ref   = '0;
    logic [31:0] mcause_ref = '0;

    // Expected cycle-by-cycle view of test 1 (trap pc=0x100 cause=11, mtvec=0x1000)
    logic        t1_we   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] t1_wa   [9] = '{12'h341, 12'h0, 12'h342, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0};
    logic [31:0] t1_wd   [9] = '{32'h100, 32'h0, 32'd11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        t1_trap [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] t1_ra   [9] = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h305, 12'h305, 12'h305, 12'h0, 12'h0};
    logic        t1_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        t1_done [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic check_writes(input string tag, input int n, input logic [31:0] pc, input logic [31:0] cause);
        check({tag, " write count"}, wlog.size(), n);
        if (wlog.size() >= 1 && n >= 1) begin
            check({tag, " mepc addr"}, {20'h0, wlog[0].addr}, 32'h341);
            check({tag, " mepc data"}, wlog[0].data, pc & ~32'h3);
        end
        if (wlog.size() >= 2 && n >= 2) begin
            check({tag, " mcause addr"}, {20'h0, wlog[1].addr}, 32'h342);
            check({tag, " mcause data"}, wlog[1].data, cause);
        end
    endtask

    task automatic wait_done(input int start, output int ticks);
        ticks = start;
        while (!trap_done && ticks < 100) begin
            tick();
            ticks++;
        end
    endtask

    // One complete transaction with optional random stalls and ignored extra requests.
    task automatic run_txn(input string tag, input bit is_trap, input bit also_mret,
                           input logic [31:0] pc, input logic [31:0] cause,
                           input bit rand_stall, input bit spurious);
        int ticks;
        int stalls;
        bit ce;
        logic [31:0] exp_target;
        wlog.delete();
        trap_valid = is_trap;
        mret_valid = !is_trap || also_mret;
        trap_pc    = pc;
        trap_cause = cause;
        clk_enable = 1'b1;
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        check({tag, " first we"}, {31'h0, csr_write_enable}, {31'h0, is_trap});
        check({tag, " first raddr"}, {20'h0, csr_read_address}, is_trap ? 32'h0 : 32'h341);
        ticks  = 0;
        stalls = 0;
        while (!trap_done && ticks < 100) begin
            ce = rand_stall ? ($urandom_range(3) != 0) : 1'b1;
            clk_enable = ce;
            if (spurious && $urandom_range(2) == 0) begin
                trap_valid = 1'b1;
                mret_valid = 1'($urandom_range(1));
                trap_pc    = $urandom;
                trap_cause = $urandom;
            end
            tick();
            ticks++;
            if (!ce) stalls++;
            trap_valid = 1'b0;
            mret_valid = 1'b0;
            clk_enable = 1'b1;
        end
        check({tag, " latency"}, ticks, (is_trap ? 7 : 3) + stalls);
        if (is_trap) begin
            mepc_ref   = pc & ~32'h3;
            mcause_ref = cause;
            exp_target = mtvec_cfg & ~32'h3;
            check_writes(tag, 2, pc, cause);
        end else begin
            exp_target = mepc_ref;
            check({tag, " write count"}, wlog.size(), 0);
        end
        check({tag, " target"}, trap_target_pc, exp_target);
        tick();
        check({tag, " back idle"}, {31'h0, trap_busy}, 32'h0);
        check({tag, " target held"}, trap_target_pc, exp_target);
    endtask

    initial begin
        int ticks;
        reset      = 1'b0;
        clk_enable = 1'b1;
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        trap_pc    = '0;
        trap_cause = '0;
        mtvec_cfg  = 32'h1000;
        #1;
        check("reset busy", {31'h0, trap_busy}, 32'h0);
        check("reset we", {31'h0, csr_write_enable}, 32'h0);
        check("reset target", trap_target_pc, 32'h0);
        check("reset done", {31'h0, trap_done}, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Test 1: full trap, cycle-by-cycle
        wlog.delete();
        trap_valid = 1'b1;
        trap_pc    = 32'h100;
        trap_cause = 32'd11;
        tick();
        trap_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t1[%0d] we", i), {31'h0, csr_write_enable}, {31'h0, t1_we[i]});
            check($sformatf("t1[%0d] waddr", i), {20'h0, csr_write_address}, {20'h0, t1_wa[i]});
            check($sformatf("t1[%0d] wdata", i), csr_write_data, t1_wd[i]);
            check($sformatf("t1[%0d] trapped", i), {31'h0, trapped}, {31'h0, t1_trap[i]});
            check($sformatf("t1[%0d] raddr", i), {20'h0, csr_read_address}, {20'h0, t1_ra[i]});
            check($sformatf("t1[%0d] busy", i), {31'h0, trap_busy}, {31'h0, t1_busy[i]});
            check($sformatf("t1[%0d] done", i), {31'h0, trap_done}, {31'h0, t1_done[i]});
            if (i >= 7) check($sformatf("t1[%0d] target", i), trap_target_pc, 32'h1000);
            tick();
        end
        check_writes("t1", 2, 32'h100, 32'd11);
        mepc_ref   = 32'h100;
        mcause_ref = 32'd11;

        // Test 2: MRET returns to mepc
        run_txn("t2", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Test 3: mtvec MODE bits dropped, misaligned pc cleared in mepc
        mtvec_cfg = 32'h2001;
        run_txn("t3", 1'b1, 1'b0, 32'h106, 32'd2, 1'b0, 1'b0);

        // Test 4: trap beats MRET; second trap during WR_CAUSE ignored
        wlog.delete();
        trap_valid = 1'b1;
        mret_valid = 1'b1;
        trap_pc    = 32'h200;
        trap_cause = 32'd3;
        tick();
        trap_valid = 1'b0;
        mret_valid = 1'b0;
        tick();
        tick();
        check("t4 in WR_CAUSE", {20'h0, csr_write_address}, 32'h342);
        trap_valid = 1'b1;
        trap_pc    = 32'h999;
        trap_cause = 32'd9;
        tick();
        trap_valid = 1'b0;
        wait_done(3, ticks);
        check("t4 latency", ticks, 7);
        check_writes("t4", 2, 32'h200, 32'd3);
        check("t4 target", trap_target_pc, 32'h2000);
        mepc_ref   = 32'h200;
        mcause_ref = 32'd3;
        tick();

        // Test 5: reset during WR_CAUSE
        wlog.delete();
        trap_valid = 1'b1;
        trap_pc    = 32'h300;
        trap_cause = 32'd7;
        tick();
        trap_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t5 busy", {31'h0, trap_busy}, 32'h0);
        check("t5 trapped", {31'h0, trapped}, 32'h0);
        check("t5 we", {31'h0, csr_write_enable}, 32'h0);
        check("t5 waddr", {20'h0, csr_write_address}, 32'h0);
        check("t5 wdata", csr_write_data, 32'h0);
        check("t5 target", trap_target_pc, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        check("t5 mepc", mepc_m, 32'h300);
        check("t5 mcause", mcause_m, mcause_ref);
        check("t5 write count", wlog.size(), 1);
        check("t5 still idle", {31'h0, trap_busy}, 32'h0);
        mepc_ref = 32'h300;

        // Test 6: clk_enable low three cycles in RD_WAIT
        mtvec_cfg = 32'h3000;
        wlog.delete();
        trap_valid = 1'b1;
        trap_pc    = 32'h400;
        trap_cause = 32'd5;
        tick();
        trap_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6 raddr", {20'h0, csr_read_address}, 32'h305);
        clk_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6 frozen raddr %0d", i), {20'h0, csr_read_address}, 32'h305);
            check($sformatf("t6 frozen done %0d", i), {31'h0, trap_done}, 32'h0);
        end
        clk_enable = 1'b1;
        wait_done(8, ticks);
        check("t6 latency", ticks, 10);
        check("t6 target", trap_target_pc, 32'h3000);
        check_writes("t6", 2, 32'h400, 32'd5);
        mepc_ref   = 32'h400;
        mcause_ref = 32'd5;
        tick();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(3) == 0) mtvec_cfg = $urandom;
            run_txn($sformatf("rnd%0d", n), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    $urandom, $urandom, 1'b1, 1'b1);
        end
        check("final mepc", mepc_m, mepc_ref);
        check("final mcause", mcause_m, mcause_ref);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
